// File: rtl/axi_axis_reader.sv
// AXI4-Lite slave exposing the most recent AXIS sample (sign-extended) plus
// NEW/OVERRUN status flags. Writes are acknowledged and discarded.
module axi_axis_reader #(
  parameter int AXI_ADDR_WIDTH  = 12,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXIS_DATA_WIDTH = 24
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready
);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  rd_state_e                  rd_state_q, rd_state_d;
  logic [AXIS_DATA_WIDTH-1:0] sample_q, sample_d;
  logic                       new_q, new_d;
  logic                       ovr_q, ovr_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                       bvalid_q, bvalid_d;

  logic                       capture, rd_acc, data_rd_acc, wr_acc;
  logic                       arready, rvalid;
  logic [AXI_DATA_WIDTH-1:0]  data_ext, status_word, rd_mux;
  logic                       unused_in;

  // Address/data of writes and the undecoded address bits carry no meaning here.
  assign unused_in = ^{s_axi_awaddr, s_axi_wdata, s_axi_araddr};

  assign capture     = s_axis_tvalid & ~rst;
  assign rd_acc      = s_axi_arvalid & arready;
  assign data_rd_acc = rd_acc & (s_axi_araddr[3:2] == REG_DATA);
  assign wr_acc      = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~rst;

  // ---------------- sample and status flags ----------------
  always_comb begin
    sample_d = capture ? s_axis_tdata : sample_q;
    // A capture in the same cycle as a DATA read leaves NEW set.
    new_d    = capture | (new_q & ~data_rd_acc);
    ovr_d    = (capture & new_q) | (ovr_q & ~data_rd_acc);
  end

  always_comb begin
    data_ext = {AXI_DATA_WIDTH{sample_q[AXIS_DATA_WIDTH-1]}};
    data_ext[AXIS_DATA_WIDTH-1:0] = sample_q;
    status_word      = '0;
    status_word[1:0] = {ovr_q, new_q};
  end

  always_comb begin
    case (s_axi_araddr[3:2])
      REG_DATA:   rd_mux = data_ext;
      REG_STATUS: rd_mux = status_word;
      default:    rd_mux = '0;
    endcase
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge aclk) begin
    if (rst) rd_state_q <= RD_IDLE;
    else     rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (rd_acc)         rd_state_d = RD_RESP;
      RD_RESP: if (s_axi_rready)   rd_state_d = RD_IDLE;
      default:                     rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    arready = (rd_state_q == RD_IDLE) & ~rst;
    rvalid  = (rd_state_q == RD_RESP) & ~rst;
  end

  // Snapshot taken at acceptance so rdata stays put while the master stalls.
  assign rdata_d = rd_acc ? rd_mux : rdata_q;

  // ---------------- write channel ----------------
  assign bvalid_d = wr_acc | (bvalid_q & ~s_axi_bready);

  always_ff @(posedge aclk) begin
    if (rst) begin
      sample_q <= '0;
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      sample_q <= sample_d;
      new_q    <= new_d;
      ovr_q    <= ovr_d;
      rdata_q  <= rdata_d;
      bvalid_q <= bvalid_d;
    end
  end

  // ---------------- outputs ----------------
  assign s_axis_tready = ~rst;
  assign s_axi_arready = arready;
  assign s_axi_rvalid  = rvalid;
  assign s_axi_rdata   = rst ? '0 : rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;
  assign s_axi_bvalid  = bvalid_q & ~rst;
  assign s_axi_bresp   = 2'b00;

endmodule

// File: tb/tb_axi_axis_reader.sv
// Directed bench for axi_axis_reader: reset, sign extension, read stall,
// status flag set/clear races, write acknowledge and reset mid-transaction.
module tb_axi_axis_reader;

  logic        aclk = 1'b0;
  logic        rst;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [23:0] tdata;
  logic        tvalid, tready;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_axis_reader #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32), .AXIS_DATA_WIDTH(24)) dut (
    .aclk(aclk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle sample capture.
  task automatic cap(input logic [23:0] td);
    @(posedge aclk); #1;
    tdata = td; tvalid = 1'b1;
    @(posedge aclk); #1;
    tvalid = 1'b0;
  endtask

  // Single read with rready=1; optional capture in the address-accept cycle.
  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag,
                    input bit with_cap = 1'b0, input logic [23:0] td = 24'h0);
    @(posedge aclk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    if (with_cap) begin tdata = td; tvalid = 1'b1; end
    @(negedge aclk);
    chk({tag, "_arready"}, {31'd0, arready}, 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0; tvalid = 1'b0;
    @(negedge aclk);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
    chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({tag, "_rvalid_drop"}, {31'd0, rvalid}, 32'd0);
  endtask

  logic [23:0] hold_vals [3];

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 1'b1; wvalid = 1'b1; wdata = '0;
    bready = 1'b0; arvalid = 1'b1; rready = 1'b0; tdata = '0; tvalid = 1'b0;
    hold_vals[0] = 24'h123456; hold_vals[1] = 24'h234567; hold_vals[2] = 24'h345678;

    // Reset state, with requests pending to prove the gating.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tready",  {31'd0, tready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    @(posedge aclk); #1;
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    chk("post_rst_tready",  {31'd0, tready},  32'd1);
    chk("post_rst_arready", {31'd0, arready}, 32'd1);

    // Positive and negative samples.
    cap(24'h0000FF);
    rd(12'h000, 32'h000000FF, "data_pos");
    cap(24'h8000FF);
    rd(12'h000, 32'hFF8000FF, "data_neg");

    // Stalled read: rdata frozen while new samples arrive.
    cap(24'h000011);
    @(posedge aclk); #1;
    araddr = 12'h000; arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    chk("stall_arready", {31'd0, arready}, 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tdata = hold_vals[i]; tvalid = 1'b1;
      @(negedge aclk);
      chk("stall_rvalid",  {31'd0, rvalid},  32'd1);
      chk("stall_rdata",   rdata, 32'h00000011);
      chk("stall_arready_busy", {31'd0, arready}, 32'd0);
      @(posedge aclk); #1;
    end
    tvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("stall_rdata_last", rdata, 32'h00000011);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("stall_rvalid_drop", {31'd0, rvalid}, 32'd0);
    chk("stall_arready_back", {31'd0, arready}, 32'd1);
    rd(12'h004, 32'h00000003, "stall_status");
    rd(12'h000, 32'h00345678, "stall_data_latest");
    rd(12'h004, 32'h00000000, "stall_status_clr");

    // Flags, decode of unused/aliased addresses.
    cap(24'h000001);
    cap(24'h000002);
    rd(12'h104, 32'h00000003, "status_alias");
    rd(12'h008, 32'h00000000, "reg_08");
    rd(12'h00C, 32'h00000000, "reg_0c");
    rd(12'h000, 32'h00000002, "data_two");
    rd(12'h004, 32'h00000000, "status_clr");

    // Capture racing a DATA read: capture wins, snapshot is the old sample.
    rd(12'h000, 32'h00000002, "race_new_data", 1'b1, 24'h7FFFFF);
    rd(12'h004, 32'h00000001, "race_new_status");
    rd(12'h000, 32'h007FFFFF, "race_ovr_data", 1'b1, 24'h000005);
    rd(12'h004, 32'h00000003, "race_ovr_status");
    rd(12'h000, 32'h00000005, "data_five");
    rd(12'h004, 32'h00000000, "status_clr2");

    // Write with stalled bready and a second request held high.
    @(posedge aclk); #1;
    awaddr = 12'h000; wdata = 32'h12345678; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge aclk);
    chk("wr_awready", {31'd0, awready}, 32'd1);
    chk("wr_wready",  {31'd0, wready},  32'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("wr_bvalid",     {31'd0, bvalid},  32'd1);
    chk("wr_bresp",      {30'd0, bresp},   32'd0);
    chk("wr_awready_bz", {31'd0, awready}, 32'd0);
    chk("wr_wready_bz",  {31'd0, wready},  32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("wr_bvalid_hold", {31'd0, bvalid}, 32'd1);
    @(posedge aclk); #1;
    bready = 1'b1;
    @(negedge aclk);
    chk("wr_bvalid_hs", {31'd0, bvalid}, 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    chk("wr_bvalid_drop", {31'd0, bvalid}, 32'd0);
    @(posedge aclk); #1;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    chk("wr2_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("wr2_bvalid_drop", {31'd0, bvalid}, 32'd0);
    rd(12'h000, 32'h00000005, "wr_data_unchanged");

    // Reset while a read response is outstanding.
    cap(24'h800000);
    @(posedge aclk); #1;
    araddr = 12'h000; arvalid = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    chk("rr_rvalid",  {31'd0, rvalid}, 32'd1);
    chk("rr_rdata",   rdata, 32'hFF800000);
    @(posedge aclk); #1;
    rst = 1'b1;
    @(negedge aclk);
    chk("rr_rvalid_rst", {31'd0, rvalid}, 32'd0);
    chk("rr_rdata_rst",  rdata, 32'd0);
    chk("rr_tready_rst", {31'd0, tready}, 32'd0);
    @(posedge aclk); #1;
    rst = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("rr_rvalid_after", {31'd0, rvalid},  32'd0);
    chk("rr_arready_after", {31'd0, arready}, 32'd1);
    rd(12'h004, 32'h00000000, "rr_status");
    rd(12'h000, 32'h00000000, "rr_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
